// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a FWFT FIFO into page-bounded DMA write bursts.
// Optional timeout drain of sub-threshold residue: define FIFO_BURST_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int BURST      = 16,
  parameter int PAGE_WORDS = 512,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] f_data,
  input  logic        f_valid,
  input  logic        f_almost_empty,
  output logic        f_read,
  input  logic [63:0] page_addr,
  input  logic        page_valid,
  output logic        page_ready,
  output logic        page_done,
  output logic        req,
  input  logic        req_ack,
  output logic [63:0] req_addr,
  output logic [4:0]  req_len,
  output logic [63:0] o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] words_total
);
  localparam int OW = $clog2(PAGE_WORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [63:0]   r_page_base;
  logic          r_page_loaded;
  logic          r_page_done;
  logic [OW-1:0] r_offset;
  logic [63:0]   r_req_addr;
  logic [4:0]    r_req_len;
  logic [4:0]    r_beat;
  logic [31:0]   r_words_total;

  logic [OW-1:0] w_remain;
  logic [4:0]    w_start_len;
  logic          w_start_full;
  logic          w_start_short;
  logic          w_start;
  logic          w_last_beat;
  logic          w_page_take;

  if (BURST < 1 || BURST > 16) begin : g_bad_burst
    $error("BURST must be in 1..16");
  end
  if ((PAGE_WORDS & (PAGE_WORDS - 1)) != 0 || (PAGE_WORDS % BURST) != 0) begin : g_bad_page
    $error("PAGE_WORDS must be a power of 2 and a multiple of BURST");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // A page is never left full while loaded, so the remainder is always >= 1.
  assign w_remain     = OW'(PAGE_WORDS) - r_offset;
  assign w_start_full = r_page_loaded & f_valid & ~f_almost_empty;
  assign w_start      = w_start_full | w_start_short;
  assign w_start_len  = w_start_full ?
                        ((w_remain >= OW'(BURST)) ? 5'(BURST) : 5'(w_remain)) : 5'd1;
  assign w_page_take  = page_valid & page_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req          = 1'b0;
    o_valid      = 1'b0;
    f_read       = 1'b0;
    w_last_beat  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_next = S_REQ;
      S_REQ: begin
        req = 1'b1;
        if (req_ack) w_state_next = S_DATA;
      end
      S_DATA: begin
        o_valid = f_valid;
        f_read  = f_valid & o_ready;
        if ((f_valid & o_ready) && (r_beat == r_req_len - 5'd1)) begin
          w_last_beat  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_page_base   <= '0;
      r_page_loaded <= 1'b0;
      r_page_done   <= 1'b0;
      r_offset      <= '0;
      r_req_addr    <= '0;
      r_req_len     <= '0;
      r_beat        <= '0;
      r_words_total <= '0;
    end else begin
      r_page_done <= 1'b0;
      if (r_state == S_IDLE && w_start) begin
        r_req_addr <= r_page_base + (64'(r_offset) << 3);
        r_req_len  <= w_start_len;
        r_beat     <= '0;
      end else if (f_read) begin
        r_beat <= r_beat + 5'd1;
      end
      if (w_last_beat) begin
        r_words_total <= r_words_total + 32'(r_req_len);
        if (r_offset + OW'(r_req_len) == OW'(PAGE_WORDS)) begin
          r_offset      <= '0;
          r_page_loaded <= 1'b0;
          r_page_done   <= 1'b1;
        end else begin
          r_offset <= r_offset + OW'(r_req_len);
        end
      end else if (w_page_take) begin
        r_page_base   <= page_addr;
        r_page_loaded <= 1'b1;
        r_offset      <= '0;
      end
    end
  end

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_fired;

  // Once fired, single-word bursts continue until the FIFO runs dry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
    end else if (!f_valid) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
    end else if (r_state == S_IDLE && f_almost_empty && r_page_loaded && !r_to_fired) begin
      if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        r_to_cnt   <= '0;
        r_to_fired <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_start_short = r_to_fired & r_page_loaded & f_valid & f_almost_empty;
`else
  assign w_start_short = 1'b0;
`endif

  // page_ready stays low during the page_done cycle so a waiting page loads one cycle later.
  assign page_ready  = ~r_page_loaded & ~r_page_done;
  assign page_done   = r_page_done;
  assign req_addr    = r_req_addr;
  assign req_len     = r_req_len;
  assign o_data      = f_data;
  assign words_total = r_words_total;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized bench with a transaction-level burst/page model.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  localparam int BURST      = 16;
  localparam int PAGE_WORDS = 32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] f_data;
  logic        f_valid;
  logic        f_almost_empty;
  logic        f_read;
  logic [63:0] page_addr;
  logic        page_valid;
  logic        page_ready;
  logic        page_done;
  logic        req;
  logic        req_ack;
  logic [63:0] req_addr;
  logic [4:0]  req_len;
  logic [63:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] words_total;

  always #5 clock = ~clock;

  fifo_burst_reader #(.BURST(BURST), .PAGE_WORDS(PAGE_WORDS), .TIMEOUT(1024)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_data(f_data), .f_valid(f_valid), .f_almost_empty(f_almost_empty), .f_read(f_read),
    .page_addr(page_addr), .page_valid(page_valid), .page_ready(page_ready),
    .page_done(page_done), .req(req), .req_ack(req_ack), .req_addr(req_addr),
    .req_len(req_len), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .words_total(words_total)
  );

  logic [63:0] fifo_q[$];
  logic [63:0] pages_q[$];
  int unsigned push_idx;
  int unsigned pop_idx;
  int          tests_run;
  int          tests_failed;

  // Reference model: current page, word offset in it, beats left in the active burst.
  bit          m_loaded;
  bit          m_done;
  bit          m_gap;
  logic [63:0] m_base;
  int          m_off;
  int          m_rem;
  int          m_len;
  logic [31:0] m_total;

  int ready_mode;
  int ack_delay;
  int req_age;
  bit ack_rand;
  int req_cycles;

  function automatic logic [63:0] mkword(input int unsigned i);
    return {~i, i};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(mkword(push_idx));
      push_idx++;
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_done = 0; m_gap = 0; m_base = '0;
    m_off = 0; m_rem = 0; m_len = 0; m_total = '0; req_age = 0;
  endtask

  task automatic reset_checks();
    check("rst_req", req, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_f_read", f_read, 0);
    check("rst_page_ready", page_ready, 1);
    check("rst_page_done", page_done, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_len", req_len, 0);
    check("rst_words_total", words_total, 0);
  endtask

  // One clock: drive inputs, check against the model, then apply the edge's effects.
  task automatic cycle();
    logic        pop;
    logic        ack_hit;
    logic        load_hit;
    logic [63:0] exp_addr;
    int          exp_len;
    bit          exp_ov;
    f_valid        = (fifo_q.size() > 0);
    f_data         = f_valid ? fifo_q[0] : 64'h0;
    f_almost_empty = (fifo_q.size() < 16);
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ~o_ready;
      default: o_ready = ($urandom_range(0, 1) == 1);
    endcase
    page_valid = (pages_q.size() > 0);
    page_addr  = page_valid ? pages_q[0] : 64'h0;
    req_ack    = req && (req_age >= ack_delay);
    #1;
    exp_len  = (PAGE_WORDS - m_off >= BURST) ? BURST : PAGE_WORDS - m_off;
    exp_addr = m_base + 64'(m_off) * 64'd8;
    exp_ov   = (m_rem > 0) && f_valid;
    check("o_valid", o_valid, exp_ov);
    check("f_read", f_read, exp_ov && o_ready);
    check("page_done", page_done, m_done);
    check("page_ready", page_ready, !m_loaded && !m_done);
    check("words_total", words_total, m_total);
    if (!(m_loaded && m_rem == 0 && !m_gap)) check("req_idle", req, 0);
    if (req) begin
      check("req_addr", req_addr, exp_addr);
      check("req_len", req_len, 64'(exp_len));
      req_cycles++;
    end
    pop      = f_read;
    ack_hit  = req & req_ack;
    load_hit = page_valid & page_ready;
    if (pop) check("o_data", o_data, mkword(pop_idx));
    @(posedge clock);
    #1;
    m_done = 0;
    m_gap  = 0;
    if (pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_idx++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_total += 32'(m_len);
          m_off   += m_len;
          m_gap    = 1;
          if (m_off == PAGE_WORDS) begin
            m_done   = 1;
            m_loaded = 0;
            m_off    = 0;
          end
        end
      end
    end
    if (ack_hit) begin
      m_len   = exp_len;
      m_rem   = exp_len;
      req_age = 0;
      $display("[TB] burst addr=0x%0h len=%0d", exp_addr, exp_len);
      if (ack_rand) ack_delay = int'($urandom_range(0, 3));
    end else if (req) begin
      req_age++;
    end
    if (load_hit) begin
      m_base   = pages_q.pop_front();
      m_loaded = 1;
      m_off    = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int unsigned target, input int budget);
    int n = 0;
    while (pop_idx < target && n < budget) begin
      cycle();
      n++;
    end
    check("drain_count", 64'(pop_idx), 64'(target));
  endtask

  initial begin
    int unsigned p0;
    int          n;
    tests_run = 0; tests_failed = 0; push_idx = 0; pop_idx = 0;
    reset_n = 1'b0; f_data = '0; f_valid = 0; f_almost_empty = 1;
    page_addr = '0; page_valid = 0; req_ack = 0; o_ready = 1;
    ready_mode = 0; ack_delay = 0; ack_rand = 0; req_cycles = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_checks();
    reset_n = 1'b1;

    // Full page in two bursts
    pages_q.push_back(64'h0000_0000_1000_0000);
    push(32);
    drain(pop_idx + 32, 500);
    idle(4);
    check("total_after_32", words_total, 32);

    // Slow ack, page change, and a page base whose bursts carry past bit 31
    ack_delay = 5;
    pages_q.push_back(64'h0000_0000_0000_2000);
    pages_q.push_back(64'h0000_0000_FFFF_FFC0);
    push(48);
    drain(pop_idx + 48, 1000);
    idle(4);

    // o_ready toggling every cycle
    ready_mode = 1; ack_delay = 0;
    push(16);
    drain(pop_idx + 16, 500);
    idle(4);

    // 15 words sit below the threshold; the 16th releases a burst
    ready_mode = 0;
    pages_q.push_back(64'h0000_0000_0000_5000);
    push(15);
    req_cycles = 0;
    p0 = pop_idx;
    idle(200);
    check("no_req_15", 64'(req_cycles), 0);
    check("no_pop_15", 64'(pop_idx), 64'(p0));
    push(1);
    drain(p0 + 16, 500);
    idle(4);

    // Randomized ready/ack/fill/page addresses
    ready_mode = 2; ack_rand = 1;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 2; k++)
        pages_q.push_back({$urandom, $urandom} & ~64'h7);
      push(int'($urandom_range(0, 40)));
      drain(pop_idx + (fifo_q.size() / 16) * 16, 3000);
      idle(3);
    end

    // Reset after 7 beats of a burst
    ready_mode = 0; ack_rand = 0; ack_delay = 0;
    pages_q.push_back(64'h0000_0000_0000_7000);
    push(32);
    n = 0;
    while (!(m_rem > 0 && m_len - m_rem == 7) && n < 500) begin
      cycle();
      n++;
    end
    check("beat7_reached", 64'(m_len - m_rem), 7);
    reset_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_checks();
    reset_n = 1'b1;
    pages_q.push_back(64'h0000_0000_0000_9000);
    drain(pop_idx + (fifo_q.size() / 16) * 16, 1000);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
